alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  2  per-requester operation request; bit N belongs to requester N.
REQ-005 req_ready  output  2  per-requester acceptance; one-cycle pulse on the granted bit only.
REQ-006 req_a  input  2*WIDTH  operand A; requester N uses bits [N*WIDTH +: WIDTH].
REQ-007 req_b  input  2*WIDTH  operand B; same packing as req_a.
REQ-008 req_sel  input  8  ALU_Sel code; requester N uses bits [N*4 +: 4].
REQ-009 rsp_valid  output  1  response holds a valid result.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_out  output  WIDTH  ALU result.
REQ-013 rsp_zero  output  1  ZeroFlag, 1 when rsp_out equals 0.

Function
REQ-014 The block SHALL share one ALU instance between two requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any req_valid bit is 1, the block SHALL grant one requester, pulse its req_ready for that cycle, latch its A/B/sel into operand registers and go to EXEC; otherwise it SHALL stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: with both bits valid, the requester not granted last wins; with one bit valid, that requester wins regardless of pointer.
REQ-017 The round-robin pointer SHALL update only on a grant, to the index granted.
REQ-018 EXEC: the ALU SHALL see only the latched operands; at the end of EXEC the block SHALL register ALU_Out, ZeroFlag and the grant index into rsp_out, rsp_zero, rsp_id and go to RESP.
REQ-019 RESP: rsp_valid SHALL be 1; the block SHALL hold rsp_out, rsp_zero, rsp_id stable until a cycle with rsp_ready=1, then drop rsp_valid and return to IDLE.
REQ-020 Latency: a grant at cycle N SHALL produce rsp_valid=1 at cycle N+2; with rsp_ready tied to 1, the minimum issue interval SHALL be 3 cycles.
REQ-021 req_ready SHALL be 0 in EXEC and RESP; requests arriving there SHALL wait, not be dropped.
REQ-022 Requesters SHALL hold req_valid and operands stable until req_ready; the block SHALL sample them only in the grant cycle.
REQ-023 Opcodes SHALL pass to the ALU unchanged: 0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 MUL, 0111 XOR.
REQ-024 Arithmetic SHALL wrap modulo 2^WIDTH: ADD/SUB discard carry, MUL returns the low WIDTH bits, and shifts use B[4:0].
REQ-025 Codes 1000-1111 SHALL produce rsp_out=0 and rsp_zero=1, and SHALL still consume a full transaction.
REQ-026 A requester holding req_valid SHALL be granted within one other grant (no starvation).

Reset
REQ-027 While rst_n=0: FSM in IDLE, req_ready=00, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0; pointer set so requester 0 wins the first contended grant.
REQ-028 Reset asserted mid-transaction SHALL discard it with no response; after rst_n rises the first grant occurs no earlier than the next rising clk edge.

Structure
REQ-029 A shared package alu_pkg SHALL hold the eight ALU_Sel opcode constants, the default WIDTH and the FSM state encoding.
REQ-030 The block SHALL instantiate the existing ALU module as its only sub-module; no arithmetic is duplicated in the arbiter.

Verification
REQ-031 Single request: req0 A=5 B=3 sel=0010, rsp_ready=1 -> req_ready=01 for one cycle, rsp_valid 2 cycles later, rsp_out=8, rsp_zero=0, rsp_id=0.
REQ-032 Contention: both valid from reset (req0 SUB 9,4; req1 MUL 3,2) -> req0 served first (rsp_out=5, id 0), then req1 (rsp_out=6, id 1); a second contended round grants req0 again.
REQ-033 Backpressure: req1 XOR 0x0F,0xF0 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_out=0xFF stable, no new grant; the response retires in the cycle rsp_ready rises.
REQ-034 Zero and illegal opcodes: SUB 5,5 -> rsp_out=0, rsp_zero=1; sel=1010 -> rsp_out=0, rsp_zero=1, a full 3-cycle transaction.
REQ-035 Shifts: SLL A=1 B=4 -> 16; SRL A=0x10 B=2 -> 4; SLL A=1 B=0x24 -> 16 (B[4:0]=4).
REQ-036 Reset mid-EXEC: rst_n low during EXEC -> outputs zero immediately, no rsp_valid afterwards; a request after rst_n rises completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated ALU: default width, ALU_Sel opcodes and FSM encoding.
package alu_pkg;

    localparam int unsigned DefaultWidth = 32;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0011;
    localparam logic [3:0] OpSub = 4'b0100;
    localparam logic [3:0] OpSrl = 4'b0101;
    localparam logic [3:0] OpMul = 4'b0110;
    localparam logic [3:0] OpXor = 4'b0111;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two requesters, the shared ALU arbiter and its consumer.
interface alu_arbiter_if #(
    parameter int unsigned WIDTH = alu_pkg::DefaultWidth
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [7:0]         req_sel;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_out;
    logic               rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_out, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: eight opcodes, results wrap modulo 2^WIDTH, undefined codes yield zero.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       sel_i,
    output logic [WIDTH-1:0] out_o,
    output logic             zero_o
);

    always_comb begin
        out_o = '0;
        case (sel_i)
            OpAnd:   out_o = a_i & b_i;
            OpOr:    out_o = a_i | b_i;
            OpAdd:   out_o = a_i + b_i;
            OpSll:   out_o = a_i << b_i[4:0];
            OpSub:   out_o = a_i - b_i;
            OpSrl:   out_o = a_i >> b_i[4:0];
            OpMul:   out_o = a_i * b_i;
            OpXor:   out_o = a_i ^ b_i;
            default: out_o = '0;
        endcase
        zero_o = (out_o == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters: grant, execute, hold response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus_io
);

    logic [1:0]       state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             gnt_idx;
    logic [1:0]       req_ready_d;
    logic [WIDTH-1:0] op_a_q, op_b_q;
    logic [3:0]       op_sel_q;
    logic             id_q;
    logic [WIDTH-1:0] rsp_out_q;
    logic             rsp_zero_q, rsp_id_q;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    // ptr_q holds the last granted index; a contended grant goes to the other one.
    always_comb begin
        gnt_idx     = (bus_io.req_valid == 2'b11) ? ~ptr_q : bus_io.req_valid[1];
        state_d     = state_q;
        ptr_d       = ptr_q;
        req_ready_d = 2'b00;
        case (state_q)
            StIdle: begin
                if (|bus_io.req_valid) begin
                    state_d              = StExec;
                    ptr_d                = gnt_idx;
                    req_ready_d[gnt_idx] = 1'b1;
                end
            end
            StExec:  state_d = StResp;
            StResp:  if (bus_io.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b1;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sel_q   <= '0;
            id_q       <= 1'b0;
            rsp_out_q  <= '0;
            rsp_zero_q <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (state_q == StIdle && (|bus_io.req_valid)) begin
                op_a_q   <= gnt_idx ? bus_io.req_a[2*WIDTH-1:WIDTH] : bus_io.req_a[WIDTH-1:0];
                op_b_q   <= gnt_idx ? bus_io.req_b[2*WIDTH-1:WIDTH] : bus_io.req_b[WIDTH-1:0];
                op_sel_q <= gnt_idx ? bus_io.req_sel[7:4] : bus_io.req_sel[3:0];
                id_q     <= gnt_idx;
            end
            if (state_q == StExec) begin
                rsp_out_q  <= alu_out;
                rsp_zero_q <= alu_zero;
                rsp_id_q   <= id_q;
            end
        end
    end

    alu_arbiter_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .sel_i  (op_sel_q),
        .out_o  (alu_out),
        .zero_o (alu_zero)
    );

    assign bus_io.req_ready = req_ready_d;
    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.rsp_out   = rsp_out_q;
    assign bus_io.rsp_zero  = rsp_zero_q;
    assign bus_io.rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arbitration order, latency, backpressure, opcodes and reset.
module tb_alu_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_arbiter_if #(.WIDTH(32)) bus ();

    alu_arbiter #(
        .WIDTH (32)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] sel);
        if (idx == 0) begin
            bus.req_a[31:0]  = a;
            bus.req_b[31:0]  = b;
            bus.req_sel[3:0] = sel;
        end else begin
            bus.req_a[63:32] = a;
            bus.req_b[63:32] = b;
            bus.req_sel[7:4] = sel;
        end
    endtask

    // Grant at N, EXEC at N+1, response checked at N+2 with rsp_ready high.
    task automatic txn(input string tag, input int idx, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] sel,
                       input logic [31:0] exp_out, input logic exp_zero);
        logic [1:0] onehot;
        onehot = (idx == 0) ? 2'b01 : 2'b10;
        step();
        load(idx, a, b, sel);
        bus.req_valid = onehot;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, ".grant"}, 64'(bus.req_ready), 64'(onehot));
        step();
        bus.req_valid = 2'b00;
        #1;
        chk({tag, ".exec_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, ".exec_valid"}, 64'(bus.rsp_valid), 64'd0);
        step();
        #1;
        chk({tag, ".valid"}, 64'(bus.rsp_valid), 64'd1);
        chk({tag, ".out"}, 64'(bus.rsp_out), 64'(exp_out));
        chk({tag, ".zero"}, 64'(bus.rsp_zero), 64'(exp_zero));
        chk({tag, ".id"}, 64'(bus.rsp_id), 64'(idx));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("rst.req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst.rsp_out", 64'(bus.rsp_out), 64'd0);
        chk("rst.rsp_zero", 64'(bus.rsp_zero), 64'd0);
        chk("rst.rsp_id", 64'(bus.rsp_id), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Contention from reset: req0 SUB 9,4 wins, then req1 MUL 3,2.
        step();
        load(0, 32'd9, 32'd4, 4'b0100);
        load(1, 32'd3, 32'd2, 4'b0110);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 1'b1;
        #1;
        chk("cont.grant0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b10;
        #1;
        chk("cont.exec0_ready", 64'(bus.req_ready), 64'b00);
        step();
        #1;
        chk("cont.rsp0_out", 64'(bus.rsp_out), 64'd5);
        chk("cont.rsp0_id", 64'(bus.rsp_id), 64'd0);
        chk("cont.resp0_ready", 64'(bus.req_ready), 64'b00);
        step();
        #1;
        chk("cont.grant1", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        #1;
        step();
        #1;
        chk("cont.rsp1_out", 64'(bus.rsp_out), 64'd6);
        chk("cont.rsp1_id", 64'(bus.rsp_id), 64'd1);
        // Second contended round: pointer now favours req0.
        step();
        load(0, 32'd2, 32'd3, 4'b0010);
        load(1, 32'd6, 32'd3, 4'b0001);
        bus.req_valid = 2'b11;
        #1;
        chk("cont2.grant0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b10;
        #1;
        step();
        #1;
        chk("cont2.rsp0_out", 64'(bus.rsp_out), 64'd5);
        step();
        #1;
        chk("cont2.grant1", 64'(bus.req_ready), 64'b10);
        step();
        bus.req_valid = 2'b00;
        #1;
        step();
        #1;
        chk("cont2.rsp1_out", 64'(bus.rsp_out), 64'd7);
        chk("cont2.rsp1_id", 64'(bus.rsp_id), 64'd1);

        txn("single_add", 0, 32'd5, 32'd3, 4'b0010, 32'd8, 1'b0);

        // Backpressure: req1 XOR held for 5 cycles while req0 waits.
        step();
        load(1, 32'h0F, 32'hF0, 4'b0111);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp.grant1", 64'(bus.req_ready), 64'b10);
        step();
        load(0, 32'hFF, 32'h0F, 4'b0000);
        bus.req_valid = 2'b01;
        #1;
        chk("bp.exec_ready", 64'(bus.req_ready), 64'b00);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk("bp.hold_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp.hold_out", 64'(bus.rsp_out), 64'hFF);
            chk("bp.hold_ready", 64'(bus.req_ready), 64'b00);
        end
        step();
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp.retire_valid", 64'(bus.rsp_valid), 64'd1);
        chk("bp.retire_id", 64'(bus.rsp_id), 64'd1);
        step();
        #1;
        chk("bp.after_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp.grant0", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b00;
        #1;
        step();
        #1;
        chk("bp.rsp0_out", 64'(bus.rsp_out), 64'h0F);
        chk("bp.rsp0_id", 64'(bus.rsp_id), 64'd0);

        txn("sub_zero", 0, 32'd5, 32'd5, 4'b0100, 32'd0, 1'b1);
        txn("illegal", 1, 32'd7, 32'd3, 4'b1010, 32'd0, 1'b1);
        txn("add_wrap", 0, 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'd1, 1'b0);
        txn("mul_low", 1, 32'h1_0001, 32'h1_0001, 4'b0110, 32'h0002_0001, 1'b0);
        txn("sll", 0, 32'd1, 32'd4, 4'b0011, 32'd16, 1'b0);
        txn("srl", 0, 32'h10, 32'd2, 4'b0101, 32'd4, 1'b0);
        txn("sll_mask", 1, 32'd1, 32'h24, 4'b0011, 32'd16, 1'b0);

        // Reset during EXEC discards the transaction.
        step();
        load(0, 32'd1, 32'd1, 4'b0010);
        bus.req_valid = 2'b01;
        #1;
        chk("rstx.grant", 64'(bus.req_ready), 64'b01);
        step();
        bus.req_valid = 2'b00;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstx.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rstx.rsp_out", 64'(bus.rsp_out), 64'd0);
        chk("rstx.rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("rstx.req_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        #1;
        chk("rstx.no_rsp1", 64'(bus.rsp_valid), 64'd0);
        step();
        #1;
        chk("rstx.no_rsp2", 64'(bus.rsp_valid), 64'd0);
        txn("post_rst_or", 1, 32'hA0, 32'h05, 4'b0001, 32'hA5, 1'b0);
        step();
        #1;
        chk("end.rsp_valid", 64'(bus.rsp_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
